mavg_sched: RTL
===============

Name: mavg_sched

Overview:
Round-robin scheduler that time-shares one moving-average datapath between NCH sample producers. Each channel keeps its own TAPS-deep sample history and running sum. Per cycle, at most one channel is granted: its sample is captured, its window is updated, and its average is emitted with the channel id one cycle later. The block sits between the per-channel sample sources and downstream logic that consumes tagged averages (mavg-style y values).

Parameters:
NCH, 4, number of requesting channels (2..8)
W, 4, sample and average width in bits
TAPS, 4, window length; power of two (2..8)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
req  input  NCH  per-channel request; source holds x stable while req is high and gnt is low
x  input  NCH*W  packed samples; channel i occupies bits [i*W +: W]
gnt  output  NCH  one-hot grant, combinational from req, clr and rr pointer; sample accepted at the clock edge where gnt[i]=1
clr  input  1  clear request for channel clr_ch
clr_ch  input  $clog2(NCH)  channel to clear
y  output  W  average of the granted channel's last TAPS samples
y_ch  output  $clog2(NCH)  channel id of y
y_valid  output  1  one-cycle pulse qualifying y/y_ch

Behaviour:
- Reset (reset=1 at a clock edge):
  - all histories, running sums, y, y_ch and y_valid go to 0.
  - rr pointer goes to 0, so channel 0 has top priority.
  - gnt is forced to 0 while reset is high.
  - A reset arriving mid-stream discards any grant in that cycle; no y_valid follows.
- Arbitration:
  - eligible[i] = req[i] and not (clr and clr_ch==i).
  - The first eligible channel at or after rr pointer p, searching upward with wrap, gets gnt.
  - When a grant occurs, p becomes (granted+1) mod NCH. Otherwise p holds.
- Accept (edge with gnt[k]=1):
  - hist[k] shifts: the new x[k] enters, and the oldest sample old_k leaves.
  - sum[k] <= sum[k] + x[k] - old_k.
  - sum width is W+$clog2(TAPS). No overflow is possible; the maximum is TAPS*(2^W-1).
- Output:
  - Registered, latency 1. The edge after acceptance sets y = new sum[k] >> $clog2(TAPS) (truncation, no rounding), y_ch = k, y_valid = 1.
  - y_valid is 0 on cycles without a grant; y and y_ch hold their last value.
- Warm-up:
  - The window is zero-filled from reset or clear, so the first TAPS outputs average in zeros.
  - No separate "window full" flag.
- Clear (clr=1 at an edge):
  - hist[clr_ch] and sum[clr_ch] go to 0.
  - That channel is masked from arbitration in the same cycle, so a clear never races an accept.
  - Other channels arbitrate and accept normally in the same cycle.
- Continuous request: a channel may hold req high across cycles. Each grant consumes exactly one sample, and the source must present the next sample after each grant.
- Idle: all req=0 gives gnt=0, no state change, and p holds.
- Out-of-range clr_ch (NCH not a power of two) is ignored.

Decomposition:
- Package mavg_pkg:
  - constants NCH, W, TAPS, SUMW = W+$clog2(TAPS), CHW = $clog2(NCH).
  - typedefs sample_t (W bits), sum_t (SUMW bits), ch_t (CHW bits).
- Sub-module rr_arb (NCH): req/mask in, one-hot gnt out, owns the rr pointer and its update. Reusable elsewhere.
- History/sum storage and the output register stay in mavg_sched.

Test Plan:
1. Single channel ramp-up: reset 3 cycles; req[0]=1, x0=4'hF held for 6 grants -> y = 3, 7, 11, 15, 15, 15 with y_ch=0; then x0=0 for 4 grants -> y = 11, 7, 3, 0.
2. Round robin: req=4'b1111 continuously, x_i=i+4 -> grant order 0,1,2,3,0,1; y_valid every cycle; y_ch follows the same order one cycle late; first outputs y=1 (4>>2), 1, 1 (6>>2), 1.
3. Fairness with a gap: req=4'b0101 -> grants alternate 0,2,0,2; drop req[2] -> channel 0 granted every cycle; idle cycles with req=0 -> gnt=0, y_valid=0, pointer unchanged.
4. Clear collision: channel 1 filled with four 8s (y=8); assert clr with clr_ch=1 while req[1]=1 -> gnt[1]=0 that cycle; the next accepted x1=8 gives y=2. Channel 3, granted in the same cycle, is unaffected.
5. Reset mid-stream: after test 1 reaches y=15, pulse reset during an active grant -> y=0, y_valid=0 the next cycle; the following grant of x0=4'hF gives y=3.
6. Back-to-back sample on the same channel with others idle: x0 = F,0,F,0 on consecutive grants -> y = 3, 3, 7, 7 (sums 15, 15, 30, 30).

Source files
------------

// File: rtl/mavg_pkg.sv
// rtl/mavg_pkg.sv - shared sizes and types for the moving-average scheduler
package mavg_pkg;
   localparam int NCH     = 4;
   localparam int W       = 4;
   localparam int TAPS    = 4;
   localparam int TAPS_LG = $clog2(TAPS);
   localparam int SUMW    = W + TAPS_LG;
   localparam int CHW     = $clog2(NCH);

   typedef logic [W-1:0]    sample_t;
   typedef logic [SUMW-1:0] sum_t;
   typedef logic [CHW-1:0]  ch_t;
endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter with masking; owns the priority pointer
module rr_arb #(
   parameter  int NCH = 4,
   localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] i_req,
   input  logic [NCH-1:0] i_mask,
   output logic [NCH-1:0] o_gnt
);
   logic [PW-1:0]  r_ptr;
   logic [PW-1:0]  w_next;
   logic [NCH-1:0] w_elig;
   logic           w_found;

   // Two passes: first the channels at/above the pointer, then the wrapped ones.
   always_comb begin
      o_gnt   = '0;
      w_next  = r_ptr;
      w_found = 1'b0;
      w_elig  = i_req & ~i_mask;
      for (int i = 0; i < NCH; i++) begin
         if (!w_found && i >= int'(r_ptr) && w_elig[i]) begin
            o_gnt[i] = 1'b1;
            w_next   = PW'((i + 1) % NCH);
            w_found  = 1'b1;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (!w_found && w_elig[i]) begin
            o_gnt[i] = 1'b1;
            w_next   = PW'((i + 1) % NCH);
            w_found  = 1'b1;
         end
      end
      if (reset) begin
         o_gnt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= w_next;
      end
   end
endmodule

// File: rtl/mavg_sched.sv
// rtl/mavg_sched.sv - time-shared moving-average datapath over NCH channels
module mavg_sched
   import mavg_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   req,
   input  logic [NCH*W-1:0] x,
   output logic [NCH-1:0]   gnt,
   input  logic             clr,
   input  ch_t              clr_ch,
   output sample_t          y,
   output ch_t              y_ch,
   output logic             y_valid
);
   sample_t        r_hist [NCH][TAPS];
   sum_t           r_sum  [NCH];
   logic [NCH-1:0] w_mask;
   ch_t            w_gidx;
   logic           w_any;
   sum_t           w_new_sum;

   // A channel being cleared cannot also be granted, so clear never races accept.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NCH; i++) begin
         w_mask[i] = clr && (clr_ch == ch_t'(i));
      end
   end

   rr_arb #(.NCH(NCH)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .i_req  (req),
      .i_mask (w_mask),
      .o_gnt  (gnt)
   );

   always_comb begin
      w_gidx = '0;
      w_any  = |gnt;
      for (int i = 0; i < NCH; i++) begin
         if (gnt[i]) w_gidx = ch_t'(i);
      end
      w_new_sum = r_sum[w_gidx] + sum_t'(x[int'(w_gidx)*W +: W])
                - sum_t'(r_hist[w_gidx][TAPS-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_sum[i] <= '0;
            for (int j = 0; j < TAPS; j++) r_hist[i][j] <= '0;
         end
         y       <= '0;
         y_ch    <= '0;
         y_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_mask[i]) begin
               r_sum[i] <= '0;
               for (int j = 0; j < TAPS; j++) r_hist[i][j] <= '0;
            end else if (gnt[i]) begin
               r_hist[i][0] <= x[i*W +: W];
               for (int j = 1; j < TAPS; j++) r_hist[i][j] <= r_hist[i][j-1];
               r_sum[i] <= w_new_sum;
            end
         end
         y_valid <= w_any;
         if (w_any) begin
            y    <= sample_t'(w_new_sum >> TAPS_LG);
            y_ch <= w_gidx;
         end
      end
   end
endmodule
